instr_encoder_loader: RTL and testbench

//  Encoder counterpart to the control-unit decoder: accepts symbolic instructions (mnemonic code +

---
 rtl/instr_encoder_loader.sv | 177 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs symbolic instructions (mnemonic + register/immediate fields) into
//   32-bit MIPS words and writes them to consecutive instruction-memory
//   addresses through a req/ack write port.
//   Optional feature: define INSTR_ENC_CHECKSUM_EN to add a 'checksum' output
//   holding the XOR of every word acknowledged since reset/start.
module instr_encoder_loader #(
  parameter int AW    = 6,
  parameter int BASE  = 0,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_mnem,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [25:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  output logic          full,
  output logic          err,
  output logic [AW:0]   count
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Low until the first edge after reset release, so in_ready stays 0 in reset.
  logic armed;

  logic        accept;
  logic        ack_take;
  logic [32:0] enc;
  logic        enc_ok;
  logic [31:0] enc_word;

  // R-type word: opcode 0, shamt 0.
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  // I-type word with a 16-bit immediate.
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // J-type word with a 26-bit target.
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

  // Returns {supported, word}. JR forces rt/rd to zero and ETH forces its
  // immediate to zero so the decoder sees canonical encodings.
  function automatic logic [32:0] encode(input logic [3:0] mnem, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [25:0] imm);
    logic [32:0] r;
    r = '0;
    case (mnem)
      4'd0:    r = {1'b1, rtype(rs, rt, rd, 6'b100000)};
      4'd1:    r = {1'b1, rtype(rs, rt, rd, 6'b100010)};
      4'd2:    r = {1'b1, rtype(rs, rt, rd, 6'b100100)};
      4'd3:    r = {1'b1, rtype(rs, rt, rd, 6'b100101)};
      4'd4:    r = {1'b1, rtype(rs, rt, rd, 6'b101010)};
      4'd5:    r = {1'b1, rtype(rs, 5'd0, 5'd0, 6'b001000)};
      4'd6:    r = {1'b1, itype(6'b100011, rs, rt, imm[15:0])};
      4'd7:    r = {1'b1, itype(6'b101011, rs, rt, imm[15:0])};
      4'd8:    r = {1'b1, itype(6'b000100, rs, rt, imm[15:0])};
      4'd9:    r = {1'b1, itype(6'b001000, rs, rt, imm[15:0])};
      4'd10:   r = {1'b1, jtype(6'b000010, imm)};
      4'd11:   r = {1'b1, jtype(6'b000011, imm)};
      4'd12:   r = {1'b1, itype(6'b100000, rs, rt, 16'h0000)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign enc      = encode(in_mnem, in_rs, in_rt, in_rd, in_imm);
  assign enc_ok   = enc[32];
  assign enc_word = enc[31:0];

  // start overrides everything, so neither a handshake nor an ack lands with it.
  assign accept   = in_valid & in_ready & ~start;
  assign ack_take = (state == WRITE) & mem_ack & ~start;
  assign full     = (count == (AW+1)'(DEPTH));

  // State register and post-reset arming flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && enc_ok) state_nxt = WRITE;
        WRITE:   if (mem_ack)          state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs derived from state and fill level only.
  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE:    in_ready = armed & ~full;
      WRITE:   mem_we   = 1'b1;
      default: ;
    endcase
  end

  // Write datapath: latch encoded word, advance address/count on ack, flag bad mnemonics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wdata <= '0;
      mem_addr  <= AW'(BASE);
      count     <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (start) begin
        mem_addr <= AW'(BASE);
        count    <= '0;
      end else begin
        if (accept) begin
          if (enc_ok) mem_wdata <= enc_word;
          else        err       <= 1'b1;
        end
        if (ack_take) begin
          mem_addr <= mem_addr + AW'(1);
          count    <= count + (AW+1)'(1);
        end
      end
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  // Running XOR of acknowledged words, updated on the same edge as count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start) begin
      checksum <= '0;
    end else if (ack_take) begin
      checksum <= checksum ^ mem_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: table-driven vectors, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_instr_encoder_loader;

  localparam int AW    = 6;
  localparam int BASE  = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_mnem = '0;
  logic [4:0]    in_rs = '0;
  logic [4:0]    in_rt = '0;
  logic [4:0]    in_rd = '0;
  logic [25:0]   in_imm = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic          full;
  logic          err;
  logic [AW:0]   count;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  always #5 clk = ~clk;

  instr_encoder_loader #(.AW(AW), .BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .full(full), .err(err), .count(count)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: format (0=R,1=I,2=J,3=unsupported) and opcode/funct per mnemonic.
  int fmt  [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 1, 3, 3, 3};
  int code [16] = '{32, 34, 36, 37, 42, 8, 35, 43, 4, 8, 2, 3, 32, 0, 0, 0};
  int          m_cnt;
  int          m_addr;
  logic [31:0] m_ck;

  typedef struct {
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [25:0] imm;
    int          dly;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [3:0] mnem, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [25:0] imm);
    logic [31:0] w;
    logic [31:0] c;
    c = 32'(code[mnem]);
    w = 32'd0;
    if (fmt[mnem] == 0) begin
      if (mnem == 4'd5) w = (32'(rs) << 21) | c;
      else              w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | c;
    end else if (fmt[mnem] == 1) begin
      w = (c << 26) | (32'(rs) << 21) | (32'(rt) << 16);
      if (mnem != 4'd12) w = w | (32'(imm) & 32'h0000FFFF);
    end else if (fmt[mnem] == 2) begin
      w = (c << 26) | (32'(imm) & 32'h03FFFFFF);
    end
    return w;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_cnt = 0; m_addr = BASE; m_ck = '0;
    chk("start_addr", mem_addr, m_addr);
    chk("start_count", count, m_cnt);
    chk("start_full", full, 0);
    chk("start_ready", in_ready, 1);
    chk("start_we", mem_we, 0);
  endtask

  // Wait (bounded) for in_ready, then present one instruction for one cycle.
  task automatic offer(input logic [3:0] mnem, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm, output bit ok);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = in_ready;
    if (!ok) begin
      chk("ready_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_mnem = mnem; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] mnem, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input int dly,
                      input logic [31:0] exp_w);
    bit ok;
    if (m_cnt == DEPTH) do_start();
    offer(mnem, rs, rt, rd, imm, ok);
    if (!ok) return;
    if (fmt[mnem] != 3) begin
      chk("we_rise", mem_we, 1);
      chk("wdata", mem_wdata, exp_w);
      chk("addr", mem_addr, m_addr);
      chk("ready_in_write", in_ready, 0);
      for (int d = 0; d < dly; d++) begin
        @(posedge clk); #1;
        chk("we_held", mem_we, 1);
        chk("wdata_held", mem_wdata, exp_w);
        chk("addr_held", mem_addr, m_addr);
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      m_cnt++; m_addr++; m_ck ^= exp_w;
      chk("we_fall", mem_we, 0);
      chk("count", count, m_cnt);
      chk("addr_next", mem_addr, m_addr);
      chk("full", full, (m_cnt == DEPTH));
      chk("ready_after", in_ready, (m_cnt < DEPTH));
`ifdef INSTR_ENC_CHECKSUM_EN
      chk("checksum", checksum, m_ck);
`endif
    end else begin
      chk("err_pulse", err, 1);
      chk("err_no_we", mem_we, 0);
      chk("err_addr", mem_addr, m_addr);
      chk("err_count", count, m_cnt);
      chk("err_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("err_clear", err, 0);
      chk("err_no_we2", mem_we, 0);
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{4'd0,  5'd1,  5'd2,  5'd3, 26'h0,       1, 32'h00221820};
    vecs[1] = '{4'd6,  5'd0,  5'd8,  5'd0, 26'h0004,    0, 32'h8C080004};
    vecs[2] = '{4'd10, 5'd0,  5'd0,  5'd0, 26'h0000010, 3, 32'h08000010};
    vecs[3] = '{4'd14, 5'd1,  5'd1,  5'd1, 26'h1,       0, 32'h0};
    vecs[4] = '{4'd9,  5'd0,  5'd1,  5'd0, 26'hFFFF,    1, 32'h2001FFFF};
    vecs[5] = '{4'd5,  5'd31, 5'd5,  5'd7, 26'h0,       2, 32'h03E00008};
    vecs[6] = '{4'd12, 5'd2,  5'd3,  5'd0, 26'h1234,    0, 32'h80430000};
    vecs[7] = '{4'd7,  5'd29, 5'd31, 5'd0, 26'hFFF8,    1, 32'hAFBFFFF8};
    vecs[8] = '{4'd8,  5'd4,  5'd5,  5'd0, 26'h0010,    2, 32'h10850010};
    vecs[9] = '{4'd11, 5'd0,  5'd0,  5'd0, 26'h3FFFFFF, 0, 32'h0FFFFFFF};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", in_ready, 1);
    m_cnt = 0; m_addr = BASE; m_ck = '0;

    // Table-driven vectors (also covers unsupported mnemonic and refill after full)
    for (int i = 0; i < 10; i++)
      send(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].dly, vecs[i].word);

    // Checksum of the first two reference words
    do_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 0, 32'h00221820);
    send(4'd6, 5'd0, 5'd8, 5'd0, 26'h0004, 0, 32'h8C080004);
`ifdef INSTR_ENC_CHECKSUM_EN
    chk("checksum_ref", checksum, 32'h8C2A1824);
`endif

    // Fill to DEPTH, then in_valid must be ignored
    send(4'd1, 5'd1, 5'd2, 5'd3, 26'h0, 0, 32'h00221822);
    send(4'd3, 5'd4, 5'd5, 5'd6, 26'h0, 1, ref_word(4'd3, 5'd4, 5'd5, 5'd6, 26'h0));
    chk("full_set", full, 1);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1; in_mnem = 4'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("full_no_we", mem_we, 0);
      chk("full_count", count, DEPTH);
      chk("full_addr", mem_addr, BASE + DEPTH);
    end
    in_valid = 1'b0;
    do_start();

    // start with in_valid in the same cycle is not accepted
    in_valid = 1'b1; in_mnem = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("start_valid_no_we", mem_we, 0);
    chk("start_valid_count", count, 0);

    // Reset while a write is pending
    offer(4'd2, 5'd1, 5'd1, 5'd1, 26'h0, ok);
    chk("pre_rst_we", mem_we, 1);
    mem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_addr", mem_addr, BASE);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    mem_ack = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count", count, 0);
    chk("post_rst_ready", in_ready, 1);
    m_cnt = 0; m_addr = BASE; m_ck = '0;

    // start coincident with mem_ack: write not counted
    send(4'd4, 5'd7, 5'd8, 5'd9, 26'h0, 0, ref_word(4'd4, 5'd7, 5'd8, 5'd9, 26'h0));
    offer(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, ok);
    chk("pre_start_we", mem_we, 1);
    start = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b0;
    chk("start_ack_count", count, 0);
    chk("start_ack_we", mem_we, 0);
    chk("start_ack_addr", mem_addr, BASE);
    m_cnt = 0; m_addr = BASE; m_ck = '0;

    // Randomized traffic against the model
    for (int r = 0; r < 60; r++) begin
      logic [3:0]  mn;
      logic [4:0]  a, b, c;
      logic [25:0] im;
      mn = 4'($urandom_range(0, 15));
      a  = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
      im = 26'($urandom);
      send(mn, a, b, c, im, int'($urandom_range(0, 3)), ref_word(mn, a, b, c, im));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
